// File: rtl/cache_pkg.sv
// Shared types and select encodings for the cache miss sequencer.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } seq_state_t;

  localparam logic CACHE_SEL_CORE  = 1'b0;
  localparam logic CACHE_SEL_MEM   = 1'b1;
  localparam logic ADDR_SEL_CORE   = 1'b0;
  localparam logic ADDR_SEL_VICTIM = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: stops at all-ones and never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cache_miss_sequencer.sv
// Write-back cache miss sequencer: victim writeback, line refill, core stall
// and datapath select decode, plus saturating miss/writeback counters.
module cache_miss_sequencer
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic             req_byte,
  input  logic             halted,
  input  logic             hit,
  input  logic             dirty,
  output logic             stall,
  output logic             cache_we,
  output logic             cache_in_select,
  output logic             mem_we,
  output logic             mem_addr_select,
  output logic             is_byte,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  seq_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       miss_inc, wb_inc;

  // Outputs are held low while reset is asserted, even though they are Mealy.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall           = 1'b0;
    cache_we        = 1'b0;
    cache_in_select = CACHE_SEL_CORE;
    mem_we          = 1'b0;
    mem_addr_select = ADDR_SEL_CORE;
    is_byte         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;
    if (rst_b) begin
      case (state_q)
        IDLE: begin
          if (req_valid && !halted) begin
            if (hit) begin
              if (req_write) begin
                cache_we = 1'b1;
                is_byte  = req_byte;
              end
            end else begin
              stall    = 1'b1;
              miss_inc = 1'b1;
              wb_inc   = dirty;
              cnt_d    = LAT_LAST;
              state_d  = dirty ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          stall           = 1'b1;
          mem_we          = 1'b1;
          mem_addr_select = ADDR_SEL_VICTIM;
          if (cnt_q == 4'd0) begin
            cnt_d   = LAT_LAST;
            state_d = REFILL;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        REFILL: begin
          stall = 1'b1;
          if (cnt_q == 4'd0) begin
            cache_we        = 1'b1;
            cache_in_select = CACHE_SEL_MEM;
            state_d         = IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Bench: per-cycle scoreboard built from planned miss schedules, plus
// directed scenarios with literal stall-length and counter expectations.
module tb_cache_miss_sequencer;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic req_valid = 1'b1, req_write = 1'b0, req_byte = 1'b0;
  logic halted = 1'b0, hit = 1'b0, dirty = 1'b0;

  logic        stall, cache_we, cache_in_select, mem_we, mem_addr_select, is_byte;
  logic [15:0] miss_count, wb_count;
  logic        stall2, cache_we2, cache_in_select2, mem_we2, mem_addr_select2, is_byte2;
  logic [1:0]  miss_count2, wb_count2;

  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  cache_miss_sequencer #(.MEM_LATENCY(L), .CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
    .req_byte(req_byte), .halted(halted), .hit(hit), .dirty(dirty),
    .stall(stall), .cache_we(cache_we), .cache_in_select(cache_in_select),
    .mem_we(mem_we), .mem_addr_select(mem_addr_select), .is_byte(is_byte),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_miss_sequencer #(.MEM_LATENCY(L), .CNT_W(2)) dut2 (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
    .req_byte(req_byte), .halted(halted), .hit(hit), .dirty(dirty),
    .stall(stall2), .cache_we(cache_we2), .cache_in_select(cache_in_select2),
    .mem_we(mem_we2), .mem_addr_select(mem_addr_select2), .is_byte(is_byte2),
    .miss_count(miss_count2), .wb_count(wb_count2)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a miss plans its whole future as a queue of per-cycle output
  // vectors {stall, cache_we, cache_sel, mem_we, addr_sel, is_byte}.
  logic [5:0] plan[$];
  int         m_miss = 0, m_wb = 0;
  bit         armed = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    logic [5:0] exp_v;
    bit         from_plan;
    exp_v = 6'b0;
    from_plan = 0;
    if (!rst_b) begin
      armed = 1;
    end else if (plan.size() != 0) begin
      exp_v = plan[0];
      from_plan = 1;
    end else if (req_valid && !halted) begin
      if (hit) exp_v = req_write ? {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, req_byte} : 6'b0;
      else     exp_v = 6'b100000;
    end
    if (armed) begin
      check("outputs", {stall, cache_we, cache_in_select, mem_we, mem_addr_select, is_byte}, exp_v);
      check("outputs_w2", {stall2, cache_we2, cache_in_select2, mem_we2, mem_addr_select2, is_byte2}, exp_v);
      if (rst_b) begin
        check("miss_count", miss_count, sat(m_miss, 65535));
        check("wb_count", wb_count, sat(m_wb, 65535));
        check("miss_count_w2", miss_count2, sat(m_miss, 3));
        check("wb_count_w2", wb_count2, sat(m_wb, 3));
      end
      if (mem_we && cache_we) check("inv_we_excl", 1, 0);
      if (mem_we && !mem_addr_select) check("inv_we_addr", 1, 0);
    end
    // advance model to the state after the coming posedge
    if (!rst_b) begin
      plan.delete();
      m_miss = 0;
      m_wb = 0;
    end else if (from_plan) begin
      void'(plan.pop_front());
    end else if (req_valid && !halted && !hit) begin
      m_miss++;
      if (dirty) begin
        m_wb++;
        for (int i = 0; i < L; i++) plan.push_back(6'b100110);
      end
      for (int i = 0; i < L - 1; i++) plan.push_back(6'b100000);
      plan.push_back(6'b111000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a miss and follow it until stall drops; drives hit=1 once the
  // refill write is seen. Optionally raises halted after halt_at stall cycles.
  task automatic run_miss(input logic wr, input logic dt, input int halt_at,
                          output int stalls);
    bit fin, done;
    req_valid = 1'b1; req_write = wr; req_byte = 1'b0; hit = 1'b0; dirty = dt;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
      fin = cache_we && cache_in_select;
      step();
      if (fin) begin
        hit = 1'b1;
        dirty = 1'b0;
      end
      if (stalls == halt_at) halted = 1'b1;
    end
    if (!done) check("miss_timeout", 0, 1);
    step();
    req_valid = 1'b0;
    halted = 1'b0;
    hit = 1'b0;
  endtask

  initial begin
    int s;
    // 1: reset with a pending miss on the inputs
    repeat (2) step();
    @(negedge clk);
    check("reset_stall", stall, 0);
    step();
    rst_b = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("reset_miss_count", miss_count, 0);
    check("reset_wb_count", wb_count, 0);

    // 2: load hit
    step();
    req_valid = 1'b1; req_write = 1'b0; hit = 1'b1;
    @(negedge clk);
    check("load_hit_stall", stall, 0);
    check("load_hit_cache_we", cache_we, 0);

    // 3: byte store hit
    step();
    req_write = 1'b1; req_byte = 1'b1;
    @(negedge clk);
    check("store_hit_we", cache_we, 1);
    check("store_hit_is_byte", is_byte, 1);
    step();
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; hit = 1'b0;
    step();

    // 4: clean load miss
    run_miss(1'b0, 1'b0, -1, s);
    check("clean_miss_stalls", s, 5);
    check("clean_miss_count", miss_count, 1);
    check("clean_wb_count", wb_count, 0);

    // 5: dirty store miss
    run_miss(1'b1, 1'b1, -1, s);
    check("dirty_miss_stalls", s, 9);
    check("dirty_miss_count", miss_count, 2);
    check("dirty_wb_count", wb_count, 1);

    // 6a: halted raised in the second writeback cycle
    run_miss(1'b1, 1'b1, 2, s);
    check("halted_mid_stalls", s, 9);
    check("halted_wb_count", wb_count, 2);

    // 6b: reset during refill
    req_valid = 1'b1; req_write = 1'b0; hit = 1'b0; dirty = 1'b0;
    repeat (3) step();
    rst_b = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_refill_stall", stall, 0);
    step();
    rst_b = 1'b1;
    @(negedge clk);
    check("rst_refill_stall_after", stall, 0);
    check("rst_refill_miss_count", miss_count, 0);
    step();

    // 6c: saturation of the 2-bit counters
    for (int k = 0; k < 5; k++) run_miss(1'b0, (k == 1), -1, s);
    @(negedge clk);
    check("sat_miss_w16", miss_count, 5);
    check("sat_miss_w2", miss_count2, 3);
    check("sat_wb_w2", wb_count2, 1);

    repeat (3) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
